hazard_stall_ctrl: RTL and testbench

//   Stall/flush controller for the 5-stage MIPS pipeline: the producing end of the hazard

---
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, memory-busy freeze,
// taken-branch flush of IF/ID, and a saturating count of PC-stall cycles.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_RSaddr_i,
    input  logic [4:0]       IFID_RTaddr_i,
    input  logic             IFID_UsesRT_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RTaddr_i,
    input  logic             Branch_taken_i,
    input  logic             Dmem_busy_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IDEX_Bubble_o,
    output logic             IFID_Flush_o,
    output logic             EXMEM_Hold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        MEMWAIT = 2'b10
    } state_t;

    localparam logic [1:0] LDCNT_INIT = 2'(LOAD_STALL_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ldcnt;
    logic [1:0]       ldcnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard;
    logic             stall_owed;

    // Load in EX writes a register the ID instruction is about to read; $0 is never a hazard.
    assign hazard = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                    ((IDEX_RTaddr_i == IFID_RSaddr_i) ||
                     (IFID_UsesRT_i && (IDEX_RTaddr_i == IFID_RTaddr_i)));

    // Remaining bubbles of an interrupted load stall are replayed once memory frees up.
    assign stall_owed = ((state == LDSTALL) || (state == MEMWAIT)) && (ldcnt != 2'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            ldcnt     <= 2'd0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            ldcnt <= ldcnt_nxt;
            if (!PC_Write_o && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        PC_Write_o    = 1'b1;
        IFID_Write_o  = 1'b1;
        IDEX_Bubble_o = 1'b0;
        IFID_Flush_o  = 1'b0;
        EXMEM_Hold_o  = 1'b0;
        state_nxt     = RUN;
        ldcnt_nxt     = 2'd0;

        if (rst_i) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Dmem_busy_i) begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            EXMEM_Hold_o = 1'b1;
            state_nxt    = MEMWAIT;
            ldcnt_nxt    = ldcnt;
        end else if (stall_owed) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
            ldcnt_nxt     = ldcnt - 2'd1;
            state_nxt     = (ldcnt == 2'd1) ? RUN : LDSTALL;
        end else if (hazard) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
                state_nxt = LDSTALL;
                ldcnt_nxt = LDCNT_INIT;
            end
        end else if (Branch_taken_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: instance a (1-cycle load stall, 16-bit counter) and
// instance b (3-cycle load stall, 4-bit counter) share the same stimulus.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, ld_rt;
    logic       uses_rt, mem_rd, br, busy;

    logic        a_pc, a_ifid, a_bub, a_flush, a_hold;
    logic [1:0]  a_state;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_bub, b_flush, b_hold;
    logic [1:0]  b_state;
    logic [3:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt), .IFID_UsesRT_i(uses_rt),
        .IDEX_MemRead_i(mem_rd), .IDEX_RTaddr_i(ld_rt),
        .Branch_taken_i(br), .Dmem_busy_i(busy),
        .PC_Write_o(a_pc), .IFID_Write_o(a_ifid), .IDEX_Bubble_o(a_bub),
        .IFID_Flush_o(a_flush), .EXMEM_Hold_o(a_hold),
        .state_o(a_state), .stall_cnt_o(a_cnt)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt), .IFID_UsesRT_i(uses_rt),
        .IDEX_MemRead_i(mem_rd), .IDEX_RTaddr_i(ld_rt),
        .Branch_taken_i(br), .Dmem_busy_i(busy),
        .PC_Write_o(b_pc), .IFID_Write_o(b_ifid), .IDEX_Bubble_o(b_bub),
        .IFID_Flush_o(b_flush), .EXMEM_Hold_o(b_hold),
        .state_o(b_state), .stall_cnt_o(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        rs = 5'd0; rt = 5'd0; ld_rt = 5'd0;
        uses_rt = 1'b0; mem_rd = 1'b0; br = 1'b0; busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_load(input logic [4:0] dst);
        mem_rd = 1'b1;
        ld_rt  = dst;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        #2;
        check("rst_pc",    32'(a_pc), 32'd0);
        check("rst_ifid",  32'(a_ifid), 32'd0);
        check("rst_bub",   32'(a_bub), 32'd1);
        check("rst_flush", 32'(a_flush), 32'd0);
        check("rst_hold",  32'(a_hold), 32'd0);
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_cnt",   32'(a_cnt), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("run_pc", 32'(a_pc), 32'd1);

        // lw $2 then add using $2 as rs: one bubble in the single-cycle config
        do_reset();
        set_load(5'd2); rs = 5'd2; rt = 5'd7; uses_rt = 1'b1;
        #1;
        check("lu_pc",   32'(a_pc), 32'd0);
        check("lu_ifid", 32'(a_ifid), 32'd0);
        check("lu_bub",  32'(a_bub), 32'd1);
        step();
        mem_rd = 1'b0;
        #1;
        check("lu_after_pc",    32'(a_pc), 32'd1);
        check("lu_after_state", 32'(a_state), 32'd0);
        check("lu_after_cnt",   32'(a_cnt), 32'd1);
        check("lu_b_state",     32'(b_state), 32'd1);

        // register $0 and the rt-use qualifier
        do_reset();
        set_load(5'd0); rs = 5'd0;
        #1;
        check("r0_pc",  32'(a_pc), 32'd1);
        check("r0_bub", 32'(a_bub), 32'd0);
        set_load(5'd5); rs = 5'd1; rt = 5'd5; uses_rt = 1'b1;
        #1;
        check("sw_rt_pc", 32'(a_pc), 32'd0);
        uses_rt = 1'b0;
        #1;
        check("sw_nort_pc", 32'(a_pc), 32'd1);

        // three-cycle load stall
        do_reset();
        set_load(5'd3); rs = 5'd3;
        #1;
        check("ls3_c0_pc",    32'(b_pc), 32'd0);
        check("ls3_c0_state", 32'(b_state), 32'd0);
        step();
        clear_in();
        #1;
        check("ls3_c1_state", 32'(b_state), 32'd1);
        check("ls3_c1_pc",    32'(b_pc), 32'd0);
        check("ls3_c1_bub",   32'(b_bub), 32'd1);
        step();
        check("ls3_c2_state", 32'(b_state), 32'd1);
        check("ls3_c2_pc",    32'(b_pc), 32'd0);
        step();
        check("ls3_c3_state", 32'(b_state), 32'd0);
        check("ls3_c3_pc",    32'(b_pc), 32'd1);
        check("ls3_b_cnt",    32'(b_cnt), 32'd3);
        check("ls3_a_cnt",    32'(a_cnt), 32'd1);

        // memory busy arrives while two load bubbles are still owed
        do_reset();
        set_load(5'd4); rs = 5'd4;
        step();
        clear_in();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("busy%0d_hold", i), 32'(b_hold), 32'd1);
            check($sformatf("busy%0d_pc", i), 32'(b_pc), 32'd0);
            check($sformatf("busy%0d_bub", i), 32'(b_bub), 32'd0);
            step();
        end
        busy = 1'b0;
        #1;
        check("mw_state", 32'(b_state), 32'd2);
        check("mw_hold",  32'(b_hold), 32'd0);
        check("mw_pc",    32'(b_pc), 32'd0);
        check("mw_bub",   32'(b_bub), 32'd1);
        check("mw_a_pc",  32'(a_pc), 32'd1);
        step();
        check("mw_s1_state", 32'(b_state), 32'd1);
        check("mw_s1_pc",    32'(b_pc), 32'd0);
        step();
        check("mw_done_state", 32'(b_state), 32'd0);
        check("mw_done_pc",    32'(b_pc), 32'd1);
        check("mw_b_cnt",      32'(b_cnt), 32'd7);
        check("mw_a_cnt",      32'(a_cnt), 32'd5);

        // branch flush, and its suppression under stalls
        do_reset();
        br = 1'b1;
        #1;
        check("br_flush", 32'(a_flush), 32'd1);
        check("br_pc",    32'(a_pc), 32'd1);
        check("br_ifid",  32'(a_ifid), 32'd1);
        step();
        br = 1'b0;
        #1;
        check("br_off_flush", 32'(a_flush), 32'd0);
        br = 1'b1; set_load(5'd6); rs = 5'd6;
        #1;
        check("br_haz_flush", 32'(a_flush), 32'd0);
        check("br_haz_bub",   32'(a_bub), 32'd1);
        clear_in();
        br = 1'b1; busy = 1'b1;
        #1;
        check("br_busy_flush", 32'(a_flush), 32'd0);

        // reset asserted between edges in the middle of a load stall
        do_reset();
        set_load(5'd8); rs = 5'd8;
        step();
        clear_in();
        step();
        check("pre_rst_state", 32'(b_state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_pc",    32'(b_pc), 32'd0);
        check("mid_rst_bub",   32'(b_bub), 32'd1);
        check("mid_rst_state", 32'(b_state), 32'd0);
        check("mid_rst_cnt",   32'(b_cnt), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_pc", 32'(b_pc), 32'd1);
        step();
        check("post_rst_state", 32'(b_state), 32'd0);

        // counter saturation on the 4-bit instance
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_b_cnt", 32'(b_cnt), 32'hF);
        check("sat_a_cnt", 32'(a_cnt), 32'd20);
        busy = 1'b0;
        step();
        check("sat_hold_cnt", 32'(b_cnt), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
